// File: rtl/alu_seq.sv
// Sequential ALU: operand/result registers, start/done handshake, eight ops.
// Build option ALU_MUL_EN enables the iterative shift-add multiplier (op 101).
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry,
  output logic                 err
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_MUL = 3'b101, OP_SHL = 3'b110, OP_SHR = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT, S_DONE} state_e;

  state_e          state_q, state_d;
  op_e             op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RW-1:0]   stage_res_q;
  logic            stage_cy_q, stage_err_q;
  logic            busy_q, done_q, zero_q, carry_q, err_q;
  logic [RW-1:0]   result_q;

  logic            accept, load_stage, busy_d, done_d;
  logic [RW-1:0]   alu_res, fin_res;
  logic            alu_cy, alu_err;
  logic [WIDTH:0]  sum;
  logic [RW-1:0]   a_ext, b_ext;

`ifdef ALU_MUL_EN
  logic [RW-1:0]    acc_q, mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             mult_last;
  assign mult_last = (cnt_q == CW'(WIDTH));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_d = (op == OP_MUL) ? S_MULT : S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_EXEC: state_d = S_DONE;
`ifdef ALU_MUL_EN
      S_MULT: if (mult_last) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy is registered, so it rises one cycle after acceptance and falls with done
  always_comb begin
    accept     = (state_q == S_IDLE) && start;
    load_stage = (state_q != S_IDLE) && (state_q != S_DONE) && (state_d == S_DONE);
    busy_d     = (state_q != S_IDLE) && (state_d != S_IDLE);
    done_d     = (state_q == S_DONE);
  end

  always_comb begin
    a_ext   = RW'(a_q);
    b_ext   = RW'(b_q);
    sum     = {1'b0, a_q} + {1'b0, b_q};
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = RW'(sum); alu_cy = sum[WIDTH]; end
      OP_SUB: begin alu_res = a_ext - b_ext; alu_cy = (a_q < b_q); end
      OP_AND: alu_res = a_ext & b_ext;
      OP_OR:  alu_res = a_ext | b_ext;
      OP_XOR: alu_res = a_ext ^ b_ext;
`ifdef ALU_MUL_EN
      OP_MUL: alu_res = '0;
`else
      OP_MUL: alu_err = 1'b1;
`endif
      OP_SHL: alu_res = a_ext << b_q[SW-1:0];
      OP_SHR: alu_res = a_ext >> b_q[SW-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  assign fin_res = (state_q == S_MULT) ? acc_q : alu_res;
`else
  assign fin_res = alu_res;
`endif

  // NOTE: pure data registers carry no reset; they are only observed after being loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op_e'(op);
      a_q  <= a;
      b_q  <= b;
    end
    if (load_stage) begin
      stage_res_q <= fin_res;
      stage_cy_q  <= (state_q == S_EXEC) && alu_cy;
      stage_err_q <= (state_q == S_EXEC) && alu_err;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= RW'(a);
      mplier_q <= b;
      cnt_q    <= '0;
    end else if ((state_q == S_MULT) && !mult_last) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (done_d) begin
        result_q <= stage_res_q;
        zero_q   <= (stage_res_q == '0);
        carry_q  <= stage_cy_q;
        err_q    <= stage_err_q;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign err    = err_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised arithmetic/logic unit with a start/done handshake. It extends the lab's 4-bit add/subtract unit in four ways:
- generic operand width;
- eight operations, including an iterative shift-add multiply;
- status flags;
- an operand/result register stage.

It sits between the switch/button input logic and the seven-segment display driver. It replaces the combinational add/subtract unit in the lab top level.

## Interface
- `WIDTH`, default 4: operand width in bits, ≥ 2. The result is 2×`WIDTH` bits.
- `clk` input, 1: system clock. All logic is on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: request an operation. Sampled only in IDLE.
- `op` input, 3: operation code, captured with `start`.
- `a` input, `WIDTH`: operand A, unsigned, captured with `start`.
- `b` input, `WIDTH`: operand B, unsigned, captured with `start`.
- `busy` output, 1: high from the cycle after acceptance until `done`.
- `done` output, 1: one-cycle pulse when `result` and the flags are updated.
- `result` output, 2×`WIDTH`: registered result. Held until the next `done`.
- `zero` output, 1: `result` == 0.
- `carry` output, 1: ADD carry-out from bit `WIDTH`−1, or SUB borrow (a < b). Otherwise 0.
- `err` output, 1: unsupported op. `result` is forced to 0.

## Operation
**Opcodes**
- 000 ADD: `result` = zero-extended a + b. `carry` = bit `WIDTH` of the sum.
- 001 SUB: `result` = a − b computed at 2×`WIDTH` bits, so underflow wraps (two's complement). `carry` = (a < b).
- 010 AND, 011 OR, 100 XOR: bitwise, zero-extended.
- 101 MUL: unsigned a × b, exact in 2×`WIDTH` bits.
- 110 SHL: a << b[`$clog2(WIDTH)`−1:0], zero-extended to 2×`WIDTH` bits, so no bits are lost.
- 111 SHR: a >> b[`$clog2(WIDTH)`−1:0], logical shift.

**FSM states**
- IDLE: `busy`=0. On `start`=1, latch op, a and b.
  - MUL goes to MULT.
  - Every other op goes to EXEC.
- EXEC: compute from the latched operands and go to DONE.
- MULT: shift-add multiply using accumulator, multiplicand and multiplier registers plus a `$clog2(WIDTH+1)`-bit counter.
  - Each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Then shift the multiplicand left and the multiplier right.
  - After exactly `WIDTH` iterations, go to DONE.
- DONE: register `result`, `zero`, `carry` and `err`, pulse `done`, then return to IDLE.

**Rules**
- `start` outside IDLE is ignored. There is no queueing.
- Operand changes after acceptance have no effect.
- `zero` is computed from the final registered `result`.
- `err` and `carry` are rewritten on every `done`.

**Reset** (any cycle, including mid-MULT)
- FSM goes to IDLE.
- `busy`, `done`, `result`, `zero`, `carry` and `err` all go to 0. `zero` is 0 out of reset even though `result`=0.
- Accumulator and counter are cleared.
- An operation in flight is discarded and produces no `done`.

## Timing
- `start` sampled high in IDLE at edge N gives `busy`=1 from N+1.
- Non-MUL ops: `done`=1 and new outputs visible after edge N+2. Latency is 2 cycles.
- MUL: `done` after edge N+`WIDTH`+2. Latency is `WIDTH`+2 cycles.
- `busy` drops in the same cycle that `done` is asserted.
- The earliest next accept is the edge after the `done` cycle, when the FSM is back in IDLE.
- `start` held high continuously gives back-to-back operations with one IDLE cycle between them.

## Configuration
- `ALU_MUL_EN` defined:
  - MUL (101) uses the MULT state as described above.
- `ALU_MUL_EN` undefined:
  - The MULT state, accumulator and counter are not synthesised.
  - Op 101 follows the EXEC path and returns `result`=0, `err`=1, `carry`=0, with 2-cycle latency.
  - All other ops are unchanged.

## Test plan
- `WIDTH`=4, ADD a=9, b=8: `done` 2 cycles after `start`. Expected `result`=0x11, `carry`=1, `zero`=0, `err`=0.
- SUB a=3, b=5: `result`=0xFE, `carry`=1. Then SUB a=7, b=7: `result`=0x00, `zero`=1, `carry`=0.
- MUL a=15, b=15 with `ALU_MUL_EN` defined: `busy` high for 5 cycles, then `result`=0xE1 with `done` at cycle 6. Without the macro: `result`=0, `err`=1 at cycle 2.
- SHL a=0xB, b=3: `result`=0x58. SHR a=0xB, b=1: `result`=0x05. XOR a=0xA, b=0xF: `result`=0x05.
- Pulse `start` again during MULT with different operands: it is ignored, and the original product is delivered.
- Assert `rst` at MULT cycle 2:
  - All outputs read 0 on the next cycle.
  - No `done` appears.
  - A following ADD 1+1 returns 0x02.
